memory_stage: RTL

- Pipeline MEM stage, directly downstream of the EX stage.
- Contains the EX/MEM pipeline register, which captures Inst, rt and AO from EX plus PC.
- Contains a word-organised data memory with byte/halfword store merging and load extension.
- Presents MO (load data) and pass-through fields to the MEM/WB register, plus a write-monitor port for the bench.

---
 rtl/memory_stage_pkg.sv | 30 +++
 rtl/memory_stage_mem_ctrl.sv | 23 ++
 rtl/memory_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared opcode constants, bubble instruction and decode types for the MEM stage.
package memory_stage_pkg;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  typedef struct packed {
    logic   is_load;
    logic   is_store;
    width_e width;
    logic   sign_ext;
  } dec_t;

  function automatic logic [5:0] op_field(input logic [31:0] inst);
    return inst[31:26];
  endfunction
endpackage

// File: rtl/memory_stage_mem_ctrl.sv
// Opcode decode for the MEM stage: access kind, width and extension mode.
module mem_ctrl
  import memory_stage_pkg::*;
(
  input  logic [5:0] i_op,
  output dec_t       o_dec
);
  always_comb begin
    o_dec          = '0;
    o_dec.width    = W_WORD;
    unique case (i_op)
      OP_LW:  begin o_dec.is_load  = 1'b1; o_dec.width = W_WORD; end
      OP_LB:  begin o_dec.is_load  = 1'b1; o_dec.width = W_BYTE; o_dec.sign_ext = 1'b1; end
      OP_LBU: begin o_dec.is_load  = 1'b1; o_dec.width = W_BYTE; end
      OP_LH:  begin o_dec.is_load  = 1'b1; o_dec.width = W_HALF; o_dec.sign_ext = 1'b1; end
      OP_LHU: begin o_dec.is_load  = 1'b1; o_dec.width = W_HALF; end
      OP_SW:  begin o_dec.is_store = 1'b1; o_dec.width = W_WORD; end
      OP_SB:  begin o_dec.is_store = 1'b1; o_dec.width = W_BYTE; end
      OP_SH:  begin o_dec.is_store = 1'b1; o_dec.width = W_HALF; end
      default: ;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register, word-organised data memory with
// byte/half store merging and sign/zero-extended loads.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int          DM_WORDS  = 4096,
  parameter int          ADDR_BITS = 12,
  parameter logic [31:0] CLR_INST  = INST_BUBBLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] Inst,
  input  logic [31:0] rt,
  input  logic [31:0] AO,
  input  logic [31:0] PC,
  output logic [31:0] Inst_out,
  output logic [31:0] AO_out,
  output logic [31:0] PC_out,
  output logic [31:0] MO,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata
);
  logic [31:0] r_inst, r_rt, r_ao, r_pc;
  logic [31:0] r_mem [DM_WORDS];

  dec_t                 w_dec;
  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          w_word, w_mo, w_merge;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [4:0]           w_bsh, w_hsh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst <= CLR_INST;
      r_rt   <= '0;
      r_ao   <= '0;
      r_pc   <= '0;
    end else if (flush) begin
      r_inst <= CLR_INST;
      r_rt   <= '0;
      r_ao   <= '0;
      r_pc   <= '0;
    end else if (en) begin
      r_inst <= Inst;
      r_rt   <= rt;
      r_ao   <= AO;
      r_pc   <= PC;
    end
  end

  mem_ctrl u_ctrl (
    .i_op  (op_field(r_inst)),
    .o_dec (w_dec)
  );

  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign w_idx  = r_ao[ADDR_BITS+1:2];
  assign w_word = r_mem[w_idx];
  assign w_bsh  = {r_ao[1:0], 3'b000};
  assign w_hsh  = {r_ao[1], 4'b0000};
  assign w_byte = w_word[w_bsh +: 8];
  assign w_half = w_word[w_hsh +: 16];

  always_comb begin
    w_mo = '0;
    if (w_dec.is_load) begin
      unique case (w_dec.width)
        W_BYTE:  w_mo = {{24{w_dec.sign_ext & w_byte[7]}}, w_byte};
        W_HALF:  w_mo = {{16{w_dec.sign_ext & w_half[15]}}, w_half};
        default: w_mo = w_word;
      endcase
    end
  end

  always_comb begin
    w_merge = w_word;
    unique case (w_dec.width)
      W_BYTE:  w_merge[w_bsh +: 8]  = r_rt[7:0];
      W_HALF:  w_merge[w_hsh +: 16] = r_rt[15:0];
      default: w_merge = r_rt;
    endcase
  end

  // A store held across a stall rewrites the same merged word each edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_dec.is_store) begin
      r_mem[w_idx] <= w_merge;
    end
  end

  assign Inst_out = r_inst;
  assign AO_out   = r_ao;
  assign PC_out   = r_pc;
  assign MO       = w_mo;
  assign dm_we    = w_dec.is_store;
  assign dm_addr  = {r_ao[31:2], 2'b00};
  assign dm_wdata = w_dec.is_store ? w_merge : 32'h0;
endmodule
